// File: rtl/joypad_if.sv
// joypad_if - NES controller port peripheral ($4016/$4017).
//
// Polls both physical pads over the latch/clock/serial-data protocol once
// every POLL_DIV cycles and presents the 4021-style strobe/shift-register
// interface to the 6502 bus.
//
// Optional build macro: JOYPAD_PAD2_EN builds the second pad (sr2, btn2,
// capture2). When it is undefined, $4017 reads return 8'h40 and btn2_dbg is 0.
//
// Ports:
//   clk_ph2       sole clock, one rising edge per CPU bus cycle
//   rst           asynchronous active-low reset
//   Addr_bus      CPU address
//   Data_bus_out  CPU write data
//   R_nW          1 = read, 0 = write
//   rd_data       read byte (combinational)
//   rd_hit        read of $4016/$4017 in progress; selects rd_data upstream
//   pad_latch     latch pulse to both pads
//   pad_clk       shift clock to both pads, idles high
//   pad1_data     pad 1 serial data, active-low
//   pad2_data     pad 2 serial data, active-low
//   btn1_dbg      committed pad 1 buttons, active-high
//   btn2_dbg      committed pad 2 buttons, active-high
module joypad_if #(
  parameter int unsigned POLL_DIV = 29780,
  parameter int unsigned PAD_HALF = 6
) (
  input  logic        clk_ph2,
  input  logic        rst,
  input  logic [15:0] Addr_bus,
  input  logic [7:0]  Data_bus_out,
  input  logic        R_nW,
  output logic [7:0]  rd_data,
  output logic        rd_hit,
  output logic        pad_latch,
  output logic        pad_clk,
  input  logic        pad1_data,
  input  logic        pad2_data,
  output logic [7:0]  btn1_dbg,
  output logic [7:0]  btn2_dbg
);

  localparam int unsigned LATCH_LEN = 2 * PAD_HALF;
  localparam int unsigned PCW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int unsigned PHW = (LATCH_LEN > 1) ? $clog2(LATCH_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CLK_LO,
    S_CLK_HI,
    S_COMMIT
  } state_t;

  state_t         state, state_nx;
  logic [PCW-1:0] poll_cnt;
  logic [PHW-1:0] phase_cnt;
  logic [2:0]     bit_idx;
  logic           poll_wrap;
  logic           phase_end;

  logic [7:0]     capture1, btn1, sr1;
  logic           strobe;

  logic           hit16, hit17, rd16, rd17, wr16;

  assign hit16  = (Addr_bus == 16'h4016);
  assign hit17  = (Addr_bus == 16'h4017);
  assign rd16   = R_nW & hit16;
  assign rd17   = R_nW & hit17;
  assign wr16   = ~R_nW & hit16;
  assign rd_hit = rd16 | rd17;

  assign poll_wrap = (poll_cnt == PCW'(POLL_DIV - 1));

  // Poll FSM: next state and phase-end detection.
  always_comb begin
    state_nx  = state;
    phase_end = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (poll_wrap) state_nx = S_LATCH;
      end
      S_LATCH: begin
        phase_end = (phase_cnt == PHW'(LATCH_LEN - 1));
        if (phase_end) state_nx = S_CLK_LO;
      end
      S_CLK_LO: begin
        phase_end = (phase_cnt == PHW'(PAD_HALF - 1));
        if (phase_end) state_nx = S_CLK_HI;
      end
      S_CLK_HI: begin
        phase_end = (phase_cnt == PHW'(PAD_HALF - 1));
        if (phase_end) state_nx = (bit_idx == 3'd7) ? S_COMMIT : S_CLK_LO;
      end
      S_COMMIT: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  assign pad_latch = (state == S_LATCH);
  assign pad_clk   = (state != S_CLK_LO);

  always_ff @(posedge clk_ph2 or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      poll_cnt  <= '0;
      phase_cnt <= '0;
      bit_idx   <= '0;
      capture1  <= '0;
      btn1      <= '0;
    end else begin
      state <= state_nx;

      if (state == S_IDLE) poll_cnt <= poll_wrap ? '0 : poll_cnt + 1'b1;
      else                 poll_cnt <= '0;

      if (phase_end || state == S_IDLE || state == S_COMMIT) phase_cnt <= '0;
      else                                                    phase_cnt <= phase_cnt + 1'b1;

      if (state == S_LATCH && phase_end) begin
        capture1[0] <= ~pad1_data;
        bit_idx     <= 3'd1;
      end
      if (state == S_CLK_HI && phase_end) begin
        capture1[bit_idx] <= ~pad1_data;
        if (bit_idx != 3'd7) bit_idx <= bit_idx + 3'd1;
      end
      if (state == S_COMMIT) btn1 <= capture1;
    end
  end

  // Strobe and pad 1 shift register. Reload while strobe is high uses the
  // registered strobe, so a write of 0 still reloads on its own edge.
  always_ff @(posedge clk_ph2 or negedge rst) begin
    if (!rst) begin
      strobe <= 1'b0;
      sr1    <= '1;
    end else begin
      if (wr16) strobe <= Data_bus_out[0];
      if (strobe)    sr1 <= btn1;
      else if (rd16) sr1 <= {1'b1, sr1[7:1]};
    end
  end

  assign btn1_dbg = btn1;

`ifdef JOYPAD_PAD2_EN
  logic [7:0] capture2, btn2, sr2;

  always_ff @(posedge clk_ph2 or negedge rst) begin
    if (!rst) begin
      capture2 <= '0;
      btn2     <= '0;
      sr2      <= '1;
    end else begin
      if (state == S_LATCH && phase_end)  capture2[0]       <= ~pad2_data;
      if (state == S_CLK_HI && phase_end) capture2[bit_idx] <= ~pad2_data;
      if (state == S_COMMIT) btn2 <= capture2;
      if (strobe)    sr2 <= btn2;
      else if (rd17) sr2 <= {1'b1, sr2[7:1]};
    end
  end

  assign btn2_dbg = btn2;

  logic unused;
  assign unused = &{1'b0, Data_bus_out[7:1]};
`else
  assign btn2_dbg = '0;

  logic unused;
  assign unused = &{1'b0, Data_bus_out[7:1], pad2_data};
`endif

  // While strobe is high the pad's A bit is passed through live, so a read in
  // the cycle right after a reload or commit already sees the new value.
  always_comb begin
    rd_data = '0;
    if (rd16) begin
      rd_data = {7'b0100000, strobe ? btn1[0] : sr1[0]};
    end else if (rd17) begin
`ifdef JOYPAD_PAD2_EN
      rd_data = {7'b0100000, strobe ? btn2[0] : sr2[0]};
`else
      rd_data = 8'h40;
`endif
    end
  end

endmodule

// File: doc/joypad_if.md
Name: joypad_if

Overview:
- CPU-bus peripheral for the NES controller ports, decoding $4016 and $4017.
- Sits directly downstream of the 6502 core: consumes Addr_bus, Data_bus_out and R_nW; returns the read byte that the top-level data mux routes onto the core's Data_bus_in.
- Autonomously polls the physical NES pads over the latch/clock/serial-data protocol once per frame-equivalent interval.
- Presents the 4021-style strobe/shift-register model to software.

Parameters:
- POLL_DIV, 29780: clk_ph2 cycles between poll starts (one NTSC frame at the CPU rate).
- PAD_HALF, 6: clk_ph2 cycles per half-period of pad_clk; the pad_latch pulse width is 2*PAD_HALF.

Ports:
- clk_ph2  in  1  sole clock; one rising edge per CPU bus cycle.
- rst  in  1  asynchronous, active-low reset.
- Addr_bus  in  16  CPU address.
- Data_bus_out  in  8  CPU write data.
- R_nW  in  1  1 = read, 0 = write.
- rd_data  out  8  read byte, combinational from Addr_bus and current state.
- rd_hit  out  1  high when R_nW=1 and Addr_bus is $4016 or $4017; the top-level mux selects rd_data when this is high.
- pad_latch  out  1  latch pulse to both pads.
- pad_clk  out  1  shift clock to both pads; idles high.
- pad1_data  in  1  pad 1 serial data, active-low (0 = pressed).
- pad2_data  in  1  pad 2 serial data, active-low.
- btn1_dbg  out  8  committed pad 1 buttons, active-high.
- btn2_dbg  out  8  committed pad 2 buttons, active-high.

Behaviour:
- Button bit order: bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
- Reset values:
  - poll counter 0, FSM IDLE.
  - pad_latch 0, pad_clk 1.
  - btn1/btn2 8'h00, capture registers 8'h00.
  - strobe 0, shift registers sr1/sr2 8'hFF.
- Reset asserted mid-poll aborts the poll immediately; the first post-reset poll starts POLL_DIV cycles after rst deasserts.
- Poll counter: counts 0..POLL_DIV-1 while in IDLE, then wraps to 0 and moves the FSM to LATCH.
- Poll FSM states:
  - IDLE: waits for counter wrap.
  - LATCH: pad_latch=1 for 2*PAD_HALF cycles. On the final cycle, capture bit0 = ~padN_data and set bit index to 1.
  - CLK_LO: pad_clk=0 for PAD_HALF cycles, then go to CLK_HI.
  - CLK_HI: pad_clk=1 for PAD_HALF cycles. On the final cycle, capture[index] = ~padN_data. If index=7 go to COMMIT, else increment index and go to CLK_LO.
  - COMMIT: one cycle; btnN <= captureN, both pads updated on the same edge; then IDLE.
- A full poll takes 2*PAD_HALF + 14*PAD_HALF + 1 cycles, 97 at default.
- CPU write (R_nW=0) to $4016: strobe <= Data_bus_out[0]. Writes to $4017 are ignored by this block (APU owns them).
- While strobe=1: sr1 <= btn1 and sr2 <= btn2 every cycle. On a COMMIT edge the shift registers take the new btn values one cycle later.
- Read $4016: rd_data = {7'b0100000, sr1[0]}, i.e. 8'h40 or 8'h41 (upper bits model open bus $40).
- Read $4017: same format using sr2[0].
- Read side effect, strobe=0: the addressed register shifts right on that clock edge, filling 1 at bit7. After 8 reads every further read returns 8'h41.
- Read side effect, strobe=1: no shift; reads always return the A bit of the live btn value.
- A write to $4016 with bit0=0 while strobe=1 freezes sr at the btn value reloaded on that same edge.
- COMMIT while strobe=0 never modifies sr.
- rd_hit=0 and rd_data=8'h00 for every other address or when R_nW=0.

Optional Feature:
- Macro JOYPAD_PAD2_EN.
- Defined: full second pad as described above.
- Undefined: sr2, btn2 and capture2 are not built; $4017 reads return 8'h40 with rd_hit still asserted; btn2_dbg is tied 8'h00; pad2_data is ignored.

Test Plan:
- Reset, then poll with pad1_data driven to model A+Start pressed (bits 0 and 3 low on the wire) -> after POLL_DIV+97 cycles btn1_dbg=8'h09; pad_latch high 12 cycles; exactly 7 pad_clk low pulses of 6 cycles each.
- btn1=8'h09; write $4016 data 8'h01, then 8'h00; 10 reads of $4016 -> 41,40,40,41,40,40,40,40,41,41.
- strobe=1, three consecutive reads of $4016 with btn1=8'h01 -> 41,41,41; sr unchanged.
- Pad 2 holds Right only (8'h80), strobe cycled, 8 reads of $4017 -> seven 40 then 41; sr1 unaffected. With JOYPAD_PAD2_EN undefined -> all reads 40.
- Poll COMMIT changes btn1 from 8'h01 to 8'h00 after 2 reads with strobe=0 -> remaining reads continue old sequence (all 40, then 41s).
- Assert rst during CLK_HI of bit 4 -> pad_clk=1, pad_latch=0, btn1_dbg=8'h00 immediately; next poll starts POLL_DIV cycles after release.
- Read $4015 and write $4017 -> rd_hit=0, rd_data=8'h00, strobe unchanged.
